// File: rtl/itch_msg_encoder_if.sv
// Order-event in / ITCH byte-stream out bundle for itch_msg_encoder.
// Latency: n/a (signal grouping only).
// Backpressure: valid_in/ready_out on the event side, valid_out/ready_in on the byte side.
//
// master: upstream event source + downstream byte sink (testbench / replay logic)
// slave : the encoder
interface itch_msg_encoder_if #(
  parameter int PRICE_WIDTH = 31,
  parameter int ID_WIDTH    = 15,
  parameter int QUANT_WIDTH = 7,
  parameter int STOCK_WIDTH = 63
);
  logic                   valid_in;
  logic                   ready_out;
  logic [2:0]             operation_in;
  logic [ID_WIDTH:0]      order_id_in;
  logic                   side_in;
  logic [QUANT_WIDTH:0]   quantity_in;
  logic [STOCK_WIDTH:0]   stock_symbol_in;
  logic [PRICE_WIDTH:0]   price_in;
  logic [7:0]             data_out;
  logic                   valid_out;
  logic                   ready_in;
  logic                   last_out;

  modport master (
    output valid_in, operation_in, order_id_in, side_in, quantity_in,
           stock_symbol_in, price_in, ready_in,
    input  ready_out, data_out, valid_out, last_out
  );

  modport slave (
    input  valid_in, operation_in, order_id_in, side_in, quantity_in,
           stock_symbol_in, price_in, ready_in,
    output ready_out, data_out, valid_out, last_out
  );
endinterface

// File: rtl/itch_msg_encoder.sv
// Serializes one add/cancel/delete order event into a length-prefixed ITCH byte frame.
// Latency: first byte one cycle after accept, then 1 byte/clk (21/25/38 bytes).
// Backpressure: byte stream holds on !ready_in; event side accepts only when idle (or on last beat with ITCH_ENC_BACK2BACK_EN).
//
// Ports: clk_in, reset_in (async, active-low); bus (itch_msg_encoder_if.slave):
//   event in  : valid_in/ready_out, operation_in, order_id_in, side_in, quantity_in, stock_symbol_in, price_in
//   stream out: data_out, valid_out/ready_in, last_out
// Optional macro ITCH_ENC_BACK2BACK_EN: accept the next event on the final beat for zero-bubble frames.
module itch_msg_encoder #(
  parameter int          PRICE_WIDTH  = 31,
  parameter int          ID_WIDTH     = 15,
  parameter int          QUANT_WIDTH  = 7,
  parameter int          STOCK_WIDTH  = 63,
  parameter logic [15:0] STOCK_LOCATE = 16'h0000
) (
  input logic               clk_in,
  input logic               reset_in,
  itch_msg_encoder_if.slave bus
);
  localparam int FRAME_W = 304;  // longest frame (ADD, 38 bytes)

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t               r_state, w_state_nxt;
  logic [FRAME_W-1:0]   r_frame, w_frame;
  logic [5:0]           r_cnt, r_len, w_len;
  logic [47:0]          r_ts;
  logic [15:0]          r_trk;
  logic                 r_rdy;
  logic                 w_legal, w_accept, w_beat, w_last, w_load;
  logic [63:0]          w_ref, w_stock;
  logic [31:0]          w_shares, w_price;
  logic [7:0]           w_side;

  // Field formatting: zero-extend numerics, left-justify the symbol over spaces.
  always_comb begin
    w_ref                          = '0;
    w_ref[ID_WIDTH:0]              = bus.order_id_in;
    w_shares                       = '0;
    w_shares[QUANT_WIDTH:0]        = bus.quantity_in;
    w_price                        = '0;
    w_price[PRICE_WIDTH:0]         = bus.price_in;
    w_stock                        = {8{8'h20}};
    w_stock[63 -: STOCK_WIDTH+1]   = bus.stock_symbol_in;
    w_side                         = bus.side_in ? 8'h42 : 8'h53;
  end

  // Whole frame is assembled at accept time and then shifted out MSB-first,
  // so the byte on data_out is always the top byte of r_frame.
  always_comb begin
    w_frame = '0;
    w_len   = '0;
    w_legal = 1'b0;
    case (bus.operation_in)
      3'b001: begin
        w_frame = {16'h0024, 8'h41, STOCK_LOCATE, r_trk, r_ts, w_ref,
                   w_side, w_shares, w_stock, w_price};
        w_len   = 6'd38;
        w_legal = 1'b1;
      end
      3'b010: begin
        w_frame = {16'h0017, 8'h58, STOCK_LOCATE, r_trk, r_ts, w_ref,
                   w_shares, 104'h0};
        w_len   = 6'd25;
        w_legal = 1'b1;
      end
      3'b011: begin
        w_frame = {16'h0013, 8'h44, STOCK_LOCATE, r_trk, r_ts, w_ref, 136'h0};
        w_len   = 6'd21;
        w_legal = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_last = (r_state == S_SEND) && (r_cnt == r_len - 6'd1);
  assign w_beat = (r_state == S_SEND) && bus.ready_in;

`ifdef ITCH_ENC_BACK2BACK_EN
  assign bus.ready_out = r_rdy | (w_last & bus.ready_in);
`else
  assign bus.ready_out = r_rdy;
`endif

  // Illegal opcodes still complete the handshake; w_legal gates the load.
  assign w_accept = bus.valid_in & bus.ready_out;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_legal) begin
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_beat && w_last) w_state_nxt = S_IDLE;
`ifdef ITCH_ENC_BACK2BACK_EN
        if (w_accept && w_legal) begin
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_frame <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_ts    <= '0;
      r_trk   <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_ts  <= r_ts + 48'd1;
      // Registered ready: low through reset, high from the first edge after release.
      r_rdy <= (w_state_nxt == S_IDLE);
      if (w_load) begin
        r_frame <= w_frame;
        r_cnt   <= '0;
        r_len   <= w_len;
        r_trk   <= r_trk + 16'd1;
      end else if (w_beat) begin
        r_frame <= r_frame << 8;
        r_cnt   <= r_cnt + 6'd1;
      end
    end
  end

  assign bus.valid_out = (r_state == S_SEND);
  assign bus.data_out  = r_frame[FRAME_W-1 -: 8];
  assign bus.last_out  = w_last;
endmodule

// File: doc/itch_msg_encoder.md
Name: itch_msg_encoder

Overview:
- Transmit-side counterpart of the ITCH parser.
- Takes one decoded order event (add / cancel / delete) per handshake and serializes it, MSB-first, into a length-prefixed ITCH byte stream.
- The stream has the exact byte layout the parser consumes.
- Used for loopback verification of the parser and as the market-data replay source feeding the decoder path.

Parameters:
- PRICE_WIDTH, 31, MSB index of price_in; zero-extended to the 32-bit price field.
- ID_WIDTH, 15, MSB index of order_id_in; zero-extended to the 64-bit order reference.
- QUANT_WIDTH, 7, MSB index of quantity_in; zero-extended to the 32-bit shares field.
- STOCK_WIDTH, 63, MSB index of stock_symbol_in. (STOCK_WIDTH+1) must be a multiple of 8 and ≤64. Left-justified in the 8-byte field; remaining bytes are 0x20.
- STOCK_LOCATE, 16'h0000, constant stock-locate field.

Ports:
- clk_in  input  1  system clock
- reset_in  input  1  asynchronous reset, active-low
- valid_in  input  1  order event valid
- ready_out  output  1  encoder can accept an event
- operation_in  input  3  3'b001 ADD, 3'b010 CANCEL, 3'b011 DELETE; all other codes illegal
- order_id_in  input  ID_WIDTH+1  order reference
- side_in  input  1  1 = buy (0x42 'B'), 0 = sell (0x53 'S'); ADD only
- quantity_in  input  QUANT_WIDTH+1  shares (ADD) / cancelled shares (CANCEL)
- stock_symbol_in  input  STOCK_WIDTH+1  ASCII symbol; ADD only
- price_in  input  PRICE_WIDTH+1  price; ADD only
- data_out  output  8  stream byte
- valid_out  output  1  data_out valid
- ready_in  input  1  downstream accepts byte
- last_out  output  1  final byte of frame

Behaviour:
- Reset (reset_in=0, asynchronous):
  - data_out=0, valid_out=0, last_out=0, ready_out=0.
  - Timestamp and tracking counters cleared; FSM forced to IDLE.
  - Reset mid-frame aborts the frame; no further bytes are emitted.
- ready_out is registered and rises on the first clk_in edge after reset release.
- FSM states: IDLE, SEND.
  - IDLE: ready_out=1. On valid_in&&ready_out, all inputs are captured into shadow registers, byte counter=0, go to SEND. valid_out rises the next cycle.
  - SEND: ready_out=0; valid_out=1; data_out = frame byte[counter].
  - A beat completes on valid_out&&ready_in, then counter increments.
  - If ready_in=0, data_out, last_out and counter hold.
  - last_out=1 only while counter==frame_len-1. The beat that completes it returns the FSM to IDLE.
- Throughput: 1 byte/clk with ready_in held high.
- Frame layout, big-endian, every message prefixed by a 2-byte length:
  - ADD: 0x0024, 'A' 0x41, locate[2], tracking[2], timestamp[6], order_ref[8], side[1], shares[4], stock[8], price[4]. 38 bytes total.
  - CANCEL: 0x0017, 'X' 0x58, locate, tracking, timestamp, order_ref, cancelled_shares[4]. 25 bytes.
  - DELETE: 0x0013, 'D' 0x44, locate, tracking, timestamp, order_ref. 21 bytes.
- Timestamp: 48-bit free-running counter.
  - Reset value 0; increments every clk_in; wraps 0xFFFF_FFFF_FFFF→0.
  - Field value = counter value on the accept edge.
- Tracking number: 16-bit counter, reset 0.
  - Field value = current count.
  - Increments by 1 after each legal message is accepted; wraps 0xFFFF→0.
- Illegal operation_in: the event is accepted (handshake completes) and silently dropped. No frame, no tracking increment, FSM stays in IDLE.
- valid_in while ready_out=0 is ignored; the upstream must hold it.

Optional Feature:
- Macro: ITCH_ENC_BACK2BACK_EN.
- Defined:
  - ready_out is also asserted in SEND while last_out&&ready_in.
  - An event accepted on that cycle starts its first byte on the next cycle, giving zero-bubble frames.
- Undefined:
  - ready_out is asserted only in IDLE.
  - There is exactly one idle cycle (valid_out=0) between consecutive frames.

Test Plan:
- Golden ADD:
  - Stimulus: accept on the edge where the timestamp counter=10. operation=001, order_id=1, side=1, quantity=1, stock="AAPL    ", price=32'h0186A000, ready_in=1.
  - Response: 38 bytes 0024_41_0000_0000_00000000000A_0000000000000001_42_00000001_4141504C20202020_0186A000; last_out on byte 38; ready_out returns high.
- DELETE followed by CANCEL:
  - Stimulus: DELETE, then CANCEL.
  - Response: tracking fields 0x0000 then 0x0001; frames of 21 and 25 bytes with lengths 0x0013 and 0x0017.
- Backpressure:
  - Stimulus: toggle ready_in pseudo-randomly during an ADD.
  - Response: byte sequence identical to the golden vector; data_out stable whenever valid_out&&!ready_in.
- Illegal op:
  - Stimulus: operation=3'b111, then a legal DELETE.
  - Response: no bytes for the illegal event; the DELETE carries tracking 0x0000.
- Reset mid-frame:
  - Stimulus: drive reset_in=0 at byte 12 of an ADD.
  - Response: valid_out=0 immediately; after release the next frame is complete, with tracking 0 and timestamp counting restarted from 0.
- Back-to-back:
  - Stimulus: two ADDs presented continuously with ready_in=1.
  - Response: 76 contiguous valid bytes with ITCH_ENC_BACK2BACK_EN defined; a single idle cycle between the two frames without it.
